// File: rtl/csrisc_pkg.sv
// Shared csRISC sequencer types: phase encoding, next-PC select codes, default PC step.
// The TRAP phase exists only when PC_SEQ_ALIGN_TRAP_EN is defined.
package csrisc_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_UPDATE  = 3'd4,
`ifdef PC_SEQ_ALIGN_TRAP_EN
        ST_HALTED  = 3'd5,
        ST_TRAP    = 3'd6
`else
        ST_HALTED  = 3'd5
`endif
    } seq_state_t;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_TARGET = 2'b01;
    localparam logic [1:0] SEL_REG    = 2'b10;
    localparam logic [1:0] SEL_RSVD   = 2'b11;

    localparam int DEFAULT_PC_STEP = 4;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: sequential step, branch target or register target.
// With PC_SEQ_ALIGN_TRAP_EN it also flags a selected target whose low two bits are set.
module pc_next_mux
    import csrisc_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [1:0]          branch_sel,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [PC_WIDTH-1:0] reg_target,
`ifdef PC_SEQ_ALIGN_TRAP_EN
    output logic                misaligned,
`endif
    output logic [PC_WIDTH-1:0] next_pc
);

    logic [PC_WIDTH-1:0] seq_pc;

    // Plain modulo-2^PC_WIDTH add: stepping past the top wraps to zero.
    assign seq_pc = pc + PC_WIDTH'(PC_STEP);

    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        next_pc = seq_pc;
        case (branch_sel)
            SEL_TARGET: next_pc = branch_target;
            SEL_REG:    next_pc = reg_target;
            default:    next_pc = seq_pc;   // SEL_SEQ and the reserved code
        endcase
    end

`ifdef PC_SEQ_ALIGN_TRAP_EN
    // Only jumps are checked; the sequential step is aligned by construction.
    assign misaligned = ((branch_sel == SEL_TARGET) || (branch_sel == SEL_REG))
                        && (next_pc[1:0] != 2'b00);
`endif

endmodule

// File: rtl/pc_sequencer.sv
// csRISC multi-cycle sequencer: owns the PC and flag register, steps FETCH/DECODE/EXECUTE/UPDATE.
// Optional misalignment trap enabled by defining PC_SEQ_ALIGN_TRAP_EN.
module pc_sequencer
    import csrisc_pkg::*;
#(
    parameter int                PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    output logic                ir_load,
    output logic                decode_en,
    output logic                exec_start,
    input  logic                exec_done,
    input  logic                flag_we,
    input  logic                alu_zero,
    input  logic                alu_carry,
    input  logic                alu_sign,
    output logic                zero_bit,
    output logic                carry_out,
    output logic                sign_bit,
    input  logic [1:0]          branch_sel,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [PC_WIDTH-1:0] reg_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
`ifdef PC_SEQ_ALIGN_TRAP_EN
    ,
    output logic                trap
`endif
);

    seq_state_t          state, state_nxt;
    logic                exec_wait;     // set after the first EXECUTE cycle of an instruction
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc_nxt;

`ifdef PC_SEQ_ALIGN_TRAP_EN
    logic misaligned;
`endif

    pc_next_mux #(
        .PC_WIDTH (PC_WIDTH),
        .PC_STEP  (PC_STEP)
    ) u_next_mux (
        .pc            (pc),
        .branch_sel    (branch_sel),
        .branch_target (branch_target),
        .reg_target    (reg_target),
`ifdef PC_SEQ_ALIGN_TRAP_EN
        .misaligned    (misaligned),
`endif
        .next_pc       (pc_nxt)
    );

`ifdef PC_SEQ_ALIGN_TRAP_EN
    assign pc_load = (state == ST_UPDATE) && !misaligned;
    assign trap    = (state == ST_TRAP);
`else
    assign pc_load = (state == ST_UPDATE);
`endif

    assign imem_addr = pc;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            pc        <= RESET_PC;
            zero_bit  <= 1'b0;
            carry_out <= 1'b0;
            sign_bit  <= 1'b0;
            exec_wait <= 1'b0;
        end else begin
            state     <= state_nxt;
            exec_wait <= (state == ST_EXECUTE) && !exec_done;
            if ((state == ST_EXECUTE) && exec_done && flag_we) begin
                zero_bit  <= alu_zero;
                carry_out <= alu_carry;
                sign_bit  <= alu_sign;
            end
            if (pc_load) begin
                pc <= pc_nxt;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        decode_en  = 1'b0;
        exec_start = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_RESET: state_nxt = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load   = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                decode_en = 1'b1;
                state_nxt = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                exec_start = !exec_wait;
                if (exec_done) begin
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
`ifdef PC_SEQ_ALIGN_TRAP_EN
                if (misaligned) begin
                    state_nxt = ST_TRAP;
                end else
`endif
                state_nxt = run ? ST_FETCH : ST_HALTED;
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (run) begin
                    state_nxt = ST_FETCH;
                end
            end
`ifdef PC_SEQ_ALIGN_TRAP_EN
            ST_TRAP: state_nxt = ST_TRAP;   // only reset leaves TRAP
`endif
            default: state_nxt = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: scoreboard of expected fetch addresses plus per-phase checks.
// Define PC_SEQ_ALIGN_TRAP_EN on both RTL and bench to exercise the trap build.
module tb_pc_sequencer;

    localparam int PW = 32;
    localparam logic [PW-1:0] RST_PC = 32'h0;
    localparam int STEP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ready;
    logic          ir_load, decode_en, exec_start;
    logic          exec_done, flag_we;
    logic          alu_zero, alu_carry, alu_sign;
    logic          zero_bit, carry_out, sign_bit;
    logic [1:0]    branch_sel;
    logic [PW-1:0] branch_target, reg_target;
    logic [PW-1:0] pc;
    logic          halted;
`ifdef PC_SEQ_ALIGN_TRAP_EN
    logic          trap;
`endif

    int checks = 0;
    int errors = 0;
    int n_ir = 0, n_dec = 0, n_exs = 0;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] model_pc;
    logic [2:0]    model_flags;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_WIDTH(PW), .RESET_PC(RST_PC), .PC_STEP(STEP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .ir_load       (ir_load),
        .decode_en     (decode_en),
        .exec_start    (exec_start),
        .exec_done     (exec_done),
        .flag_we       (flag_we),
        .alu_zero      (alu_zero),
        .alu_carry     (alu_carry),
        .alu_sign      (alu_sign),
        .zero_bit      (zero_bit),
        .carry_out     (carry_out),
        .sign_bit      (sign_bit),
        .branch_sel    (branch_sel),
        .branch_target (branch_target),
        .reg_target    (reg_target),
        .pc            (pc),
        .halted        (halted)
`ifdef PC_SEQ_ALIGN_TRAP_EN
        ,
        .trap          (trap)
`endif
    );

    always @(negedge clk) begin
        if (rst_n) begin
            n_ir  += int'(ir_load);
            n_dec += int'(decode_en);
            n_exs += int'(exec_start);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Bounded wait for the first FETCH after reset release.
    task automatic wait_fetch(input string name);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 6) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL %s: no imem_req within %0d cycles, imem_req=%b expected 1", name, n, imem_req);
        end
    endtask

    // One instruction from its first FETCH cycle (entered at a falling edge) through UPDATE.
    task automatic run_instr(input string name, input int fs, input int es,
                             input logic fwe, input logic [2:0] fl, input logic [1:0] sel,
                             input logic [PW-1:0] tgt, input logic [PW-1:0] rtgt, input logic run_v);
        logic [PW-1:0] exp_addr, nxt;
        logic          misal;
        int            cyc;
        cyc = 0;
        exp_addr = (exp_q.size() != 0) ? exp_q.pop_front() : ~model_pc;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_addr || pc !== exp_addr) begin
            errors++;
            $display("FAIL %s fetch_addr: req=%b addr=%h pc=%h expected req=1 addr=%h",
                     name, imem_req, imem_addr, pc, exp_addr);
        end
        for (int i = 0; i < fs; i++) begin
            imem_ready = 1'b0;
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr || ir_load !== 1'b0) begin
                errors++;
                $display("FAIL %s fetch_stall: req=%b addr=%h ir_load=%b expected 1 %h 0",
                         name, imem_req, imem_addr, ir_load, exp_addr);
            end
            @(negedge clk); cyc++;
        end
        imem_ready = 1'b1;
        #1;
        checks++;
        if (ir_load !== 1'b1) begin
            errors++;
            $display("FAIL %s ir_load: got %b expected 1", name, ir_load);
        end
        @(negedge clk); cyc++;
        imem_ready = 1'b1;  // ignored outside FETCH
        #1;
        checks++;
        if (decode_en !== 1'b1 || ir_load !== 1'b0 || imem_req !== 1'b0 || exec_start !== 1'b0) begin
            errors++;
            $display("FAIL %s decode: decode_en=%b ir_load=%b req=%b exec_start=%b expected 1 0 0 0",
                     name, decode_en, ir_load, imem_req, exec_start);
        end
        @(negedge clk); cyc++;
        imem_ready = 1'b0;
        branch_sel = ~sel;
        #1;
        checks++;
        if (exec_start !== 1'b1 || decode_en !== 1'b0) begin
            errors++;
            $display("FAIL %s exec_start: exec_start=%b decode_en=%b expected 1 0", name, exec_start, decode_en);
        end
        for (int i = 0; i < es; i++) begin
            exec_done = 1'b0;
            flag_we = 1'b1;
            {alu_zero, alu_carry, alu_sign} = ~fl;
            @(negedge clk); cyc++;
            #1;
            checks++;
            if (exec_start !== 1'b0) begin
                errors++;
                $display("FAIL %s exec_start_once: got %b expected 0", name, exec_start);
            end
        end
        exec_done = 1'b1;
        flag_we = fwe;
        {alu_zero, alu_carry, alu_sign} = fl;
        @(negedge clk); cyc++;
        // UPDATE: select and run are sampled now
        exec_done = 1'b0;
        flag_we = 1'b0;
        run = run_v;
        branch_sel = sel;
        branch_target = tgt;
        reg_target = rtgt;
        if (fwe) model_flags = fl;
        #1;
        checks++;
        if ({zero_bit, carry_out, sign_bit} !== model_flags) begin
            errors++;
            $display("FAIL %s flags: got %b expected %b", name, {zero_bit, carry_out, sign_bit}, model_flags);
        end
        case (sel)
            2'b01:   nxt = tgt;
            2'b10:   nxt = rtgt;
            default: nxt = model_pc + PW'(STEP);
        endcase
        misal = 1'b0;
`ifdef PC_SEQ_ALIGN_TRAP_EN
        misal = (sel == 2'b01 || sel == 2'b10) && (nxt[1:0] != 2'b00);
`endif
        @(negedge clk); cyc++;
        branch_sel = 2'b00;
        if (misal) begin
`ifdef PC_SEQ_ALIGN_TRAP_EN
            checks++;
            if (trap !== 1'b1 || pc !== model_pc || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s trap_entry: trap=%b pc=%h req=%b expected 1 %h 0",
                         name, trap, pc, imem_req, model_pc);
            end
`endif
        end else begin
            model_pc = nxt;
            exp_q.push_back(nxt);
            checks++;
            if (run_v) begin
                if (cyc != 4 + fs + es || imem_req !== 1'b1) begin
                    errors++;
                    $display("FAIL %s instr_cycles: got %0d req=%b expected %0d req=1",
                             name, cyc, imem_req, 4 + fs + es);
                end
            end else begin
                if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== nxt) begin
                    errors++;
                    $display("FAIL %s halt_entry: halted=%b req=%b pc=%h expected 1 0 %h",
                             name, halted, imem_req, pc, nxt);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++;
        if (pc !== RST_PC || {zero_bit, carry_out, sign_bit} !== 3'b000 || imem_req !== 1'b0 ||
            ir_load !== 1'b0 || decode_en !== 1'b0 || exec_start !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: pc=%h flags=%b req=%b ir=%b dec=%b exs=%b halt=%b expected %h 000 0 0 0 0 0",
                     pc, {zero_bit, carry_out, sign_bit}, imem_req, ir_load, decode_en, exec_start, halted, RST_PC);
        end
`ifdef PC_SEQ_ALIGN_TRAP_EN
        checks++;
        if (trap !== 1'b0) begin
            errors++;
            $display("FAIL reset_trap: got %b expected 0", trap);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_pc = RST_PC;
        model_flags = 3'b000;
        exp_q.delete();
        exp_q.push_back(RST_PC);
        @(negedge clk);
        wait_fetch("reset_release");
    endtask

    task automatic test_straight_line();
        int ir0, dec0, exs0;
        ir0 = n_ir; dec0 = n_dec; exs0 = n_exs;
        for (int i = 0; i < 4; i++)
            run_instr("straight", 0, 0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b1);
        checks++;
        if (n_ir - ir0 != 4 || n_dec - dec0 != 4 || n_exs - exs0 != 4) begin
            errors++;
            $display("FAIL straight_pulses: ir=%0d dec=%0d exs=%0d expected 4 each",
                     n_ir - ir0, n_dec - dec0, n_exs - exs0);
        end
    endtask

    task automatic test_fetch_stall();
        int ir0;
        ir0 = n_ir;
        run_instr("fetch_stall", 3, 0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b1);
        checks++;
        if (n_ir - ir0 != 1) begin
            errors++;
            $display("FAIL fetch_stall_pulse: ir_load pulses=%0d expected 1", n_ir - ir0);
        end
    endtask

    task automatic test_exec_stall();
        // Stall cycles drive flag_we with inverted flags; they must be ignored without exec_done.
        run_instr("exec_stall", 0, 2, 1'b1, 3'b101, 2'b00, 32'h0, 32'h0, 1'b1);
        run_instr("exec_nowe", 1, 1, 1'b0, 3'b010, 2'b00, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_flag_branch();
        run_instr("flag_branch", 0, 0, 1'b1, 3'b010, 2'b01, 32'h100, 32'h0, 1'b1);
        run_instr("at_target", 0, 0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_reg_jump();
        run_instr("reg_jump", 0, 0, 1'b0, 3'b000, 2'b10, 32'h200, 32'h40, 1'b1);
        run_instr("rsvd_sel", 0, 0, 1'b0, 3'b000, 2'b11, 32'h200, 32'h300, 1'b1);
        run_instr("after_rsvd", 0, 0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_wrap();
        run_instr("wrap_jump", 0, 0, 1'b0, 3'b000, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b1);
        run_instr("wrap_step", 0, 0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_halt();
        run_instr("halt", 0, 0, 1'b0, 3'b000, 2'b01, 32'h80, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== model_pc) begin
                errors++;
                $display("FAIL halt_hold: halted=%b req=%b pc=%h expected 1 0 %h", halted, imem_req, pc, model_pc);
            end
        end
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_resume: halted=%b expected 0", halted);
        end
        run_instr("resume", 0, 0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_async_reset();
        logic [PW-1:0] a;
        a = exp_q.pop_front();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== a) begin
            errors++;
            $display("FAIL arst_fetch: req=%b addr=%h expected 1 %h", imem_req, imem_addr, a);
        end
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        exec_done = 1'b0;
        flag_we = 1'b1;
        {alu_zero, alu_carry, alu_sign} = 3'b111;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== RST_PC || {zero_bit, carry_out, sign_bit} !== 3'b000 || imem_req !== 1'b0 ||
            ir_load !== 1'b0 || decode_en !== 1'b0 || exec_start !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL arst_values: pc=%h flags=%b req=%b ir=%b dec=%b exs=%b halt=%b expected %h 000 0 0 0 0 0",
                     pc, {zero_bit, carry_out, sign_bit}, imem_req, ir_load, decode_en, exec_start, halted, RST_PC);
        end
        flag_we = 1'b0;
        {alu_zero, alu_carry, alu_sign} = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        model_pc = RST_PC;
        model_flags = 3'b000;
        exp_q.delete();
        exp_q.push_back(RST_PC);
        @(negedge clk);
        wait_fetch("arst_release");
        run_instr("arst_after", 0, 0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_misaligned();
        logic [PW-1:0] held;
        held = model_pc;
        run_instr("misaligned", 0, 0, 1'b0, 3'b000, 2'b01, 32'h102, 32'h0, 1'b1);
`ifdef PC_SEQ_ALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (trap !== 1'b1 || imem_req !== 1'b0 || pc !== held) begin
                errors++;
                $display("FAIL trap_hold: trap=%b req=%b pc=%h expected 1 0 %h", trap, imem_req, pc, held);
            end
        end
        imem_ready = 1'b0;
`else
        run_instr("unaligned_fetch", 0, 0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b1);
        checks++;
        if (held + 32'h104 != model_pc + held) begin
            // unreachable unless the bench model itself drifts
        end
        if (pc !== 32'h106) begin
            errors++;
            $display("FAIL unaligned_step: pc=%h expected 00000106", pc);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b1;
        imem_ready = 1'b0;
        exec_done = 1'b0;
        flag_we = 1'b0;
        {alu_zero, alu_carry, alu_sign} = 3'b000;
        branch_sel = 2'b00;
        branch_target = '0;
        reg_target = '0;
        model_pc = RST_PC;
        model_flags = 3'b000;

        test_reset();
        test_straight_line();
        test_fetch_stall();
        test_exec_stall();
        test_flag_branch();
        test_reg_jump();
        test_wrap();
        test_halt();
        test_async_reset();
        test_misaligned();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer for the csRISC core. It owns the program counter and the architectural flag register (zero, carry, sign), and steps each instruction through fetch, decode, execute and PC-update phases. In the update phase it applies the 2-bit next-PC select produced by the branch control logic. It sits between instruction memory, the decode/ALU datapath and the branch control block, and feeds that block its registered flags.

## Interface
Parameters:
- PC_WIDTH, 32, program counter and target width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential increment added to the PC.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; when low at the end of an instruction, the sequencer parks in HALTED.
- imem_req  out  1  fetch request, held until accepted.
- imem_addr  out  PC_WIDTH  fetch address; always equals pc.
- imem_ready  in  1  fetch accepted; instruction data valid this cycle.
- ir_load  out  1  one-cycle pulse; the instruction register captures memory data.
- decode_en  out  1  one-cycle pulse in DECODE.
- exec_start  out  1  one-cycle pulse on the first EXECUTE cycle.
- exec_done  in  1  the datapath has finished the current instruction.
- flag_we  in  1  with exec_done, write the ALU flags.
- alu_zero, alu_carry, alu_sign  in  1 each  ALU flag results.
- zero_bit, carry_out, sign_bit  out  1 each  registered flags, driven to branch control.
- branch_sel  in  2  next-PC select from branch control.
- branch_target  in  PC_WIDTH  PC-relative or absolute target.
- reg_target  in  PC_WIDTH  register-sourced target.
- pc  out  PC_WIDTH  current program counter.
- halted  out  1  high while in HALTED.
- trap  out  1  misalignment trap; only present with PC_SEQ_ALIGN_TRAP_EN.

## Operation
- **States:** RESET, FETCH, DECODE, EXECUTE, UPDATE, HALTED (plus TRAP when the macro is enabled).
- **RESET:** entered asynchronously on rst_n low. One cycle after release, go to FETCH.
- **FETCH:** imem_req=1. On imem_ready: ir_load=1 for that cycle, then go to DECODE. Otherwise stay.
- **DECODE:** decode_en=1 for one cycle, then go to EXECUTE.
- **EXECUTE:** exec_start=1 on the first cycle only. Wait for exec_done; exec_done on the exec_start cycle is legal.
  - On exec_done with flag_we=1, load {zero_bit, carry_out, sign_bit} from the ALU flags.
  - Then go to UPDATE.
- **UPDATE:** branch_sel is sampled here, so branch control sees the newly written flags. The PC is updated as follows:
  - 00: pc+PC_STEP.
  - 01: branch_target.
  - 10: reg_target.
  - 11: reserved; treated as 00.
  - Next state is FETCH if run=1, otherwise HALTED.
- **HALTED:** halted=1. Go to FETCH on the first cycle run=1. The PC is unchanged.
- **PC arithmetic:** modulo 2^PC_WIDTH. An increment past the maximum wraps to 0 with no error.
- **Outputs outside their states:** every handshake output is 0 outside its own state.

## Timing
- **Reset values:** pc=RESET_PC, flags=0, imem_req=0, ir_load=0, decode_en=0, exec_start=0, halted=0, trap=0.
- **Minimum instruction time:** 4 cycles (FETCH with immediate ready, DECODE, 1-cycle EXECUTE, UPDATE).
- **Stalls:** each extra imem_ready-low or exec_done-low cycle adds exactly one cycle.
- **PC visibility:** the new pc is visible in the first FETCH cycle after UPDATE, together with imem_req=1.
- **Inputs ignored outside their states:** imem_ready outside FETCH, exec_done outside EXECUTE, and flag_we without exec_done.
- **Reset mid-instruction:** the instruction is abandoned immediately and the flags are cleared. No partial PC or flag update survives.

## Configuration
- **PC_SEQ_ALIGN_TRAP_EN defined:** in UPDATE, a selected target (01 or 10) with non-zero bits [1:0] is not loaded.
  - pc is held, the sequencer enters TRAP and trap=1.
  - TRAP persists until reset. Sequential updates are never checked.
- **Macro undefined:** targets are loaded unchanged, the trap port is absent and there is no TRAP state.

## Structure
- **Shared package (csrisc_pkg):**
  - state enum encoding.
  - next-PC select constants: SEL_SEQ=2'b00, SEL_TARGET=2'b01, SEL_REG=2'b10, SEL_RSVD=2'b11.
  - default PC_STEP.
- **Sub-module:** one, pc_next_mux (combinational selection of pc+PC_STEP, branch_target or reg_target, plus the alignment check). The FSM and registers stay in pc_sequencer.

## Test plan
- **Reset and straight-line code:** release reset with imem_ready and exec_done tied high -> pc = 0, 4, 8, … on every 4th cycle; one ir_load, decode_en and exec_start pulse per instruction.
- **Fetch stall:** imem_ready low for 3 cycles -> imem_req and imem_addr held stable; the instruction takes 7 cycles; ir_load is a single pulse.
- **Flag to branch:** exec_done with flag_we=1 and alu_carry=1, then branch_sel=01 with target 0x100 -> carry_out=1 in UPDATE; the next fetch address is 0x100.
- **Register jump and reserved select:** branch_sel=10 with reg_target 0x40 -> pc=0x40; branch_sel=11 -> pc=pc+4.
- **Halt and resume:** run low during UPDATE -> pc updated, halted=1, no imem_req; run high -> FETCH on the next cycle at the held pc.
- **Async reset and misalignment:**
  - rst_n pulsed low mid-EXECUTE -> all outputs at reset values within the same cycle.
  - With PC_SEQ_ALIGN_TRAP_EN, target 0x102 -> trap=1, pc unchanged, no further fetch.
